mcs4_rom_arbiter: RTL and testbench
===================================

MCS4_ROM_ARBITER -- requirements
Module: mcs4_rom_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 12, program memory address width; SHALL equal mcs4::Addr_width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock, shared with the CPU.
- rst_n in 1: reset, synchronous, active-low.
- sync in 1: CPU sync output, high during the X3 cycle.
- cpu_dbus_in in 4: CPU dbus_out, carries address nibbles during A1..A3.
- cpu_dbus_out out 4: drives the CPU dbus_in.
- mem_en out 1: program memory access strobe.
- mem_we out 1: program memory write.
- mem_addr out ADDR_W: program memory address.
- mem_wdata out 8: program memory write data.
- mem_rdata in 8: program memory read data, valid the cycle after mem_en with mem_we low.
- host_req in 1: host access request, held until host_ack.
- host_we in 1: host write (1) or read (0).
- host_addr in ADDR_W: host address.
- host_wdata in 8: host write data.
- host_ack out 1: one-cycle completion pulse.
- host_rdata out 8: read data, valid with host_ack.
- locked out 1: phase tracker is aligned to the CPU.
- sync_err out 1: sticky misalignment flag.
- fetch_cnt out 16: count of CPU fetches.

Function
REQ-003 Phase tracker: while unlocked, sync high SHALL set phase=A1 next cycle and set locked. While locked, phase SHALL increment modulo 8 (A1,A2,A3,M1,M2,X1,X2,X3).
REQ-004 While locked, sync high with phase!=X3 SHALL set sync_err (sticky) and force phase=A1 next cycle. sync low with phase==X3 SHALL set sync_err and keep counting.
REQ-005 Address capture: phase A1 latches cpu_dbus_in into addr[3:0]. Phase A2 latches addr[7:4].
REQ-006 CPU fetch, phase A3 while locked:
- mem_en=1, mem_we=0.
- mem_addr={cpu_dbus_in, addr[7:4], addr[3:0]}, combinational from cpu_dbus_in.
- fetch_cnt increments, wrapping 0xFFFF->0.
REQ-007 Phase M1: cpu_dbus_out=mem_rdata[7:4] (OPR), and mem_rdata SHALL be latched into fetch_buf. Phase M2: cpu_dbus_out=fetch_buf[3:0] (OPA). All other phases, and always when unlocked: cpu_dbus_out=0.
REQ-008 CPU fetch has absolute priority. A host access SHALL NOT be issued in a phase-A3 cycle while locked. A host access MAY be issued in any other cycle, or in any cycle while unlocked.
REQ-009 Host FSM states IDLE, RD_WAIT, ACK:
- IDLE, host_req=1, slot legal: issue mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata. A write goes to ACK; a read goes to RD_WAIT.
- RD_WAIT: capture mem_rdata into host_rdata, go to ACK.
- ACK: host_ack=1 for one cycle, return to IDLE. A host_req still high in ACK is not reissued until IDLE.
- Slot illegal: stay in IDLE; the request stays pending.
REQ-010 A host read issued in phase A2 SHALL return in A3 without corrupting the CPU fetch issued in A3. Host latency SHALL be at most 3 cycles, including one A3 stall.
REQ-011 mem_en SHALL be asserted by at most one source per cycle. mem_en=0, mem_we=0 when idle.
REQ-012 host_rdata SHALL hold its value until the next host read completes.

Reset
REQ-013 While rst_n=0 at the clock edge, the following SHALL all be 0: locked, sync_err, phase (A1), fetch_cnt, addr, fetch_buf, host_rdata, host_ack, cpu_dbus_out, mem_en, mem_we, mem_addr, mem_wdata. Host FSM SHALL be IDLE.
REQ-014 Reset mid-host-access SHALL abandon the access with no host_ack. The host SHALL reissue it.

Structure
REQ-015 char_t, addr_t and instr_cyc_t SHALL come from package mcs4. The host FSM state enum SHALL be added to mcs4 as rom_arb_state_t.
REQ-016 The phase tracker (REQ-003/004) SHALL be the sub-module mcs4_phase_tracker (outputs phase, locked, sync_err), so that the RAM-side controllers can reuse it.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then sync pulse: locked=1 next cycle, phase=A1. Memory at 0x000 = 0xD5: cpu_dbus_out=0xD in M1, 0x5 in M2, fetch_cnt=1.
- Bus nibbles 0x3, 0x2, 0x1 in A1..A3: mem_addr=0x123 in A3. Memory 0x123 = 0xA7 gives OPR 0xA, OPA 0x7.
- Host write 0x5C to 0x0FF in phase M1: mem_we=1 that cycle, host_ack next cycle. A later host read of 0x0FF returns host_rdata=0x5C.
- Host read requested in phase A3: no mem_en from host in A3, issue in M1, host_ack in X1. The CPU fetch is unchanged.
- sync asserted in phase M2: sync_err=1 and stays set, phase=A1 next cycle, fetches continue.
- Reset asserted in RD_WAIT: no host_ack; all outputs per REQ-013 next cycle.

Source files
------------

// File: rtl/mcs4_rom_arbiter_pkg.sv
// Shared MCS-4 types for the ROM arbiter and the RAM-side controllers.
package mcs4;
  localparam int Addr_width = 12;

  typedef logic [3:0]            char_t;
  typedef logic [Addr_width-1:0] addr_t;

  // One instruction cycle is eight clocks, starting at A1.
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ACK} rom_arb_state_t;
endpackage

// File: rtl/mcs4_rom_arbiter_if.sv
// Host access port of the ROM arbiter: request/ack handshake plus data.
interface mcs4_rom_arbiter_if #(parameter int ADDR_W = mcs4::Addr_width);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;

  modport master (output host_req, host_we, host_addr, host_wdata,
                  input  host_ack, host_rdata);
  modport slave  (input  host_req, host_we, host_addr, host_wdata,
                  output host_ack, host_rdata);
endinterface

// File: rtl/mcs4_rom_arbiter_phase_tracker.sv
// Follows the CPU instruction cycle from its sync pulse; flags any misalignment.
module mcs4_phase_tracker
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  output instr_cyc_t phase,
  output logic       locked,
  output logic       sync_err
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= A1;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else if (!locked) begin
      if (sync) begin
        phase  <= A1;
        locked <= 1'b1;
      end
    end else if (sync && phase != X3) begin
      sync_err <= 1'b1;
      phase    <= A1;
    end else begin
      // A missing sync at X3 is reported but the count keeps running.
      if (!sync && phase == X3) sync_err <= 1'b1;
      phase <= instr_cyc_t'(phase + 3'd1);
    end
  end

endmodule

// File: rtl/mcs4_rom_arbiter.sv
// Program memory arbiter: serves MCS-4 CPU fetches and slots host accesses
// into the cycles the CPU leaves free.
//
// state      | meaning
// ST_IDLE    | waiting for host_req; issues it when the slot is not a CPU fetch
// ST_RD_WAIT | host read in flight, mem_rdata captured into host_rdata
// ST_ACK     | host_ack high for one cycle
module mcs4_rom_arbiter
  import mcs4::*;
#(
  parameter int ADDR_W = Addr_width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync,
  input  char_t             cpu_dbus_in,
  output char_t             cpu_dbus_out,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  mcs4_rom_arbiter_if.slave host,
  output logic              locked,
  output logic              sync_err,
  output logic [15:0]       fetch_cnt
);

  instr_cyc_t     phase;
  rom_arb_state_t state;
  logic [7:0]     addr;
  char_t          fetch_buf;
  logic           cpu_fetch;
  logic           host_issue;

  mcs4_phase_tracker u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync     (sync),
    .phase    (phase),
    .locked   (locked),
    .sync_err (sync_err)
  );

  // The rst_n qualifier keeps the memory strobes quiet while reset is held.
  assign cpu_fetch  = rst_n && locked && phase == A3;
  assign host_issue = rst_n && state == ST_IDLE && host.host_req
                      && !(locked && phase == A3);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_fetch) begin
      mem_en   = 1'b1;
      mem_addr = ADDR_W'({cpu_dbus_in, addr});
    end else if (host_issue) begin
      mem_en    = 1'b1;
      mem_we    = host.host_we;
      mem_addr  = host.host_addr;
      mem_wdata = host.host_wdata;
    end
  end

  // OPR is forwarded live from memory in M1; only OPA needs to be held for M2.
  always_comb begin
    cpu_dbus_out = '0;
    if (rst_n && locked) begin
      case (phase)
        M1:      cpu_dbus_out = mem_rdata[7:4];
        M2:      cpu_dbus_out = fetch_buf;
        default: cpu_dbus_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      fetch_buf <= '0;
      fetch_cnt <= '0;
    end else if (locked) begin
      case (phase)
        A1:      addr[3:0] <= cpu_dbus_in;
        A2:      addr[7:4] <= cpu_dbus_in;
        A3:      fetch_cnt <= fetch_cnt + 16'd1;
        M1:      fetch_buf <= mem_rdata[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      host.host_ack   <= 1'b0;
      host.host_rdata <= '0;
    end else begin
      host.host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_issue) begin
            state         <= host.host_we ? ST_ACK : ST_RD_WAIT;
            host.host_ack <= host.host_we;
          end
        end
        ST_RD_WAIT: begin
          host.host_rdata <= mem_rdata;
          host.host_ack   <= 1'b1;
          state           <= ST_ACK;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_rom_arbiter.sv
// Directed bench for mcs4_rom_arbiter: CPU instruction cycles with host
// accesses placed in chosen phases, against a simple program memory model.
module tb_mcs4_rom_arbiter;
  import mcs4::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync;
  logic [3:0]  cpu_dbus_in;
  logic [3:0]  cpu_dbus_out;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        locked;
  logic        sync_err;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  en_v, we_v, ack_v;
  logic [11:0] addr_v [8];
  logic [7:0]  wdata_v [8];
  logic [3:0]  dout_v [8];

  mcs4_rom_arbiter_if host_if ();

  mcs4_rom_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync         (sync),
    .cpu_dbus_in  (cpu_dbus_in),
    .cpu_dbus_out (cpu_dbus_out),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .host         (host_if),
    .locked       (locked),
    .sync_err     (sync_err),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Program memory: preset contents plus anything written since time zero.
  logic [7:0]    mem [4096];
  logic [4095:0] written = '0;

  function automatic logic [7:0] rom_init(input logic [11:0] a);
    case (a)
      12'h000: return 8'hD5;
      12'h123: return 8'hA7;
      12'h654: return 8'h96;
      12'h456: return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : rom_init(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Runs ncyc clocks from A1, driving nibbles in A1..A3 and sync/host_req per
  // phase mask; records the DUT outputs seen in every phase.
  task automatic instr(input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3,
                       input int ncyc, input logic [7:0] sync_mask, input logic [7:0] req_mask);
    logic [2:0] p;
    en_v  = '0;
    we_v  = '0;
    ack_v = '0;
    for (int ph = 0; ph < ncyc; ph++) begin
      p = 3'(ph);
      @(posedge clk); #2;
      sync             = sync_mask[p];
      cpu_dbus_in      = (p == 3'd0) ? n1 : (p == 3'd1) ? n2 : (p == 3'd2) ? n3 : 4'h0;
      host_if.host_req = req_mask[p];
      #1;
      en_v[p]    = mem_en;
      we_v[p]    = mem_we;
      ack_v[p]   = host_if.host_ack;
      addr_v[p]  = mem_addr;
      wdata_v[p] = mem_wdata;
      dout_v[p]  = cpu_dbus_out;
      if (p == 3'd0) begin
        chk("locked_a1", 16'(locked), 16'h1);
        chk("phase_a1", 16'(dut.u_phase.phase), 16'h0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst_n              = 1'b0;
    sync               = 1'b0;
    cpu_dbus_in        = 4'h0;
    host_if.host_req   = 1'b0;
    host_if.host_we    = 1'b0;
    host_if.host_addr  = 12'h000;
    host_if.host_wdata = 8'h00;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_sync_err", 16'(sync_err), 16'h0);
    chk("rst_fetch_cnt", fetch_cnt, 16'h0);
    chk("rst_mem_en", 16'(mem_en), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    chk("rst_dbus_out", 16'(cpu_dbus_out), 16'h0);
    chk("rst_host_ack", 16'(host_if.host_ack), 16'h0);
    chk("rst_host_rdata", 16'(host_if.host_rdata), 16'h0);

    // First sync pulse: still unlocked in this cycle, A1 next cycle.
    @(posedge clk); #2;
    rst_n = 1'b1;
    sync  = 1'b1;
    #1;
    chk("unlocked_at_sync", 16'(locked), 16'h0);

    // Fetch from 0x000 = 0xD5.
    instr(4'h0, 4'h0, 4'h0, 8, 8'h80, 8'h00);
    chk("i1_en", 16'(en_v), 16'h04);
    chk("i1_we", 16'(we_v), 16'h00);
    chk("i1_addr", 16'(addr_v[2]), 16'h000);
    chk("i1_opr", 16'(dout_v[3]), 16'hD);
    chk("i1_opa", 16'(dout_v[4]), 16'h5);
    chk("i1_x1_dout", 16'(dout_v[5]), 16'h0);
    chk("i1_fetch_cnt", fetch_cnt, 16'h1);

    // Fetch from 0x123 = 0xA7.
    instr(4'h3, 4'h2, 4'h1, 8, 8'h80, 8'h00);
    chk("i2_addr", 16'(addr_v[2]), 16'h123);
    chk("i2_opr", 16'(dout_v[3]), 16'hA);
    chk("i2_opa", 16'(dout_v[4]), 16'h7);
    chk("i2_fetch_cnt", fetch_cnt, 16'h2);

    // Host write 0x5C -> 0x0FF issued in M1, ack in M2.
    host_if.host_we    = 1'b1;
    host_if.host_addr  = 12'h0FF;
    host_if.host_wdata = 8'h5C;
    instr(4'h4, 4'h5, 4'h6, 8, 8'h80, 8'h08);
    chk("i3_en", 16'(en_v), 16'h0C);
    chk("i3_we", 16'(we_v), 16'h08);
    chk("i3_host_addr", 16'(addr_v[3]), 16'h0FF);
    chk("i3_host_wdata", 16'(wdata_v[3]), 16'h5C);
    chk("i3_ack", 16'(ack_v), 16'h10);
    chk("i3_cpu_addr", 16'(addr_v[2]), 16'h654);
    chk("i3_opr", 16'(dout_v[3]), 16'h9);
    chk("i3_opa", 16'(dout_v[4]), 16'h6);
    chk("i3_fetch_cnt", fetch_cnt, 16'h3);

    // Host read of 0x0FF requested in A3: stalled to M1, ack in X1.
    host_if.host_we = 1'b0;
    instr(4'h3, 4'h2, 4'h1, 8, 8'h80, 8'h3C);
    chk("i4_en", 16'(en_v), 16'h0C);
    chk("i4_we", 16'(we_v), 16'h00);
    chk("i4_ack", 16'(ack_v), 16'h20);
    chk("i4_cpu_addr", 16'(addr_v[2]), 16'h123);
    chk("i4_host_addr", 16'(addr_v[3]), 16'h0FF);
    chk("i4_opr", 16'(dout_v[3]), 16'hA);
    chk("i4_opa", 16'(dout_v[4]), 16'h7);
    chk("i4_host_rdata", 16'(host_if.host_rdata), 16'h5C);
    chk("i4_fetch_cnt", fetch_cnt, 16'h4);

    // Host read of 0x456 issued in A2 returns in A3 alongside the CPU fetch.
    host_if.host_addr = 12'h456;
    instr(4'h0, 4'h0, 4'h0, 8, 8'h80, 8'h0E);
    chk("i5_en", 16'(en_v), 16'h06);
    chk("i5_ack", 16'(ack_v), 16'h08);
    chk("i5_host_addr", 16'(addr_v[1]), 16'h456);
    chk("i5_cpu_addr", 16'(addr_v[2]), 16'h000);
    chk("i5_opr", 16'(dout_v[3]), 16'hD);
    chk("i5_opa", 16'(dout_v[4]), 16'h5);
    chk("i5_host_rdata", 16'(host_if.host_rdata), 16'h3C);
    chk("i5_sync_err", 16'(sync_err), 16'h0);
    chk("i5_fetch_cnt", fetch_cnt, 16'h5);

    // Stray sync in M2 cuts the cycle short.
    instr(4'h0, 4'h0, 4'h0, 5, 8'h10, 8'h00);
    chk("i6_opr", 16'(dout_v[3]), 16'hD);
    chk("i6_opa", 16'(dout_v[4]), 16'h5);
    chk("i6_sync_err_m2", 16'(sync_err), 16'h0);
    chk("i6_fetch_cnt", fetch_cnt, 16'h6);

    // Realigned at A1; host write 0x77 -> 0x0F0 in X1.
    host_if.host_we    = 1'b1;
    host_if.host_addr  = 12'h0F0;
    host_if.host_wdata = 8'h77;
    instr(4'h3, 4'h2, 4'h1, 8, 8'h80, 8'h20);
    chk("i7_sync_err", 16'(sync_err), 16'h1);
    chk("i7_opr", 16'(dout_v[3]), 16'hA);
    chk("i7_opa", 16'(dout_v[4]), 16'h7);
    chk("i7_en", 16'(en_v), 16'h24);
    chk("i7_we", 16'(we_v), 16'h20);
    chk("i7_ack", 16'(ack_v), 16'h40);
    chk("i7_rdata_hold", 16'(host_if.host_rdata), 16'h3C);
    chk("i7_fetch_cnt", fetch_cnt, 16'h7);

    // CPU fetches the byte the host just wrote.
    instr(4'h0, 4'hF, 4'h0, 8, 8'h80, 8'h00);
    chk("i8_addr", 16'(addr_v[2]), 16'h0F0);
    chk("i8_opr", 16'(dout_v[3]), 16'h7);
    chk("i8_opa", 16'(dout_v[4]), 16'h7);
    chk("i8_sync_err", 16'(sync_err), 16'h1);
    chk("i8_fetch_cnt", fetch_cnt, 16'h8);

    // Host read issued in A1, reset applied during RD_WAIT.
    @(posedge clk); #2;
    sync              = 1'b0;
    host_if.host_we   = 1'b0;
    host_if.host_addr = 12'h123;
    host_if.host_req  = 1'b1;
    #1;
    chk("rw_issue_en", 16'(mem_en), 16'h1);
    @(posedge clk); #2;
    rst_n            = 1'b0;
    host_if.host_req = 1'b0;
    @(posedge clk); #1;
    chk("rw_host_ack", 16'(host_if.host_ack), 16'h0);
    chk("rw_locked", 16'(locked), 16'h0);
    chk("rw_sync_err", 16'(sync_err), 16'h0);
    chk("rw_fetch_cnt", fetch_cnt, 16'h0);
    chk("rw_host_rdata", 16'(host_if.host_rdata), 16'h0);
    chk("rw_mem_en", 16'(mem_en), 16'h0);
    chk("rw_mem_addr", 16'(mem_addr), 16'h0);
    chk("rw_dbus_out", 16'(cpu_dbus_out), 16'h0);
    chk("rw_phase", 16'(dut.u_phase.phase), 16'h0);

    @(posedge clk); #2;
    rst_n = 1'b1;
    sync  = 1'b1;
    #1;
    chk("rw_ack_after", 16'(host_if.host_ack), 16'h0);

    // Host reissues the read in X1 after relock.
    instr(4'h0, 4'h0, 4'h0, 8, 8'h80, 8'hE0);
    chk("rr_en", 16'(en_v), 16'h24);
    chk("rr_ack", 16'(ack_v), 16'h80);
    chk("rr_host_rdata", 16'(host_if.host_rdata), 16'hA7);
    chk("rr_opr", 16'(dout_v[3]), 16'hD);
    chk("rr_fetch_cnt", fetch_cnt, 16'h1);
    host_if.host_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
